// File: rtl/crash_scanner.sv
// Multi-enemy collision scanner: snapshots player/enemy positions on start, tests one
// enemy slot per clock against the player hit zone, then publishes mask, first hit and sticky crash.
module crash_scanner #(
  parameter int N_ENEMY = 8,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int RADIUS  = 38,
  parameter int PCX     = 40,
  parameter int PCY     = 41,
  parameter int P0X     = 32,
  parameter int P0Y     = 77,
  parameter int P1X     = 2,
  parameter int P1Y     = 30,
  parameter int P2X     = 62,
  parameter int P2Y     = 30,
  localparam int IDXW   = $clog2(N_ENEMY)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [XW-1:0]         pl_x,
  input  logic [YW-1:0]         pl_y,
  input  logic [N_ENEMY*XW-1:0] en_x,
  input  logic [N_ENEMY*YW-1:0] en_y,
  input  logic [N_ENEMY-1:0]    en_valid,
  input  logic                  crash_ack,
  output logic                  busy,
  output logic                  done,
  output logic [N_ENEMY-1:0]    hit_mask,
  output logic                  hit_any,
  output logic [IDXW-1:0]       first_hit_idx,
  output logic                  crash
);

  localparam int SXW = XW + 2;
  localparam int SYW = YW + 2;
  localparam int MW  = ((SXW > SYW) ? SXW : SYW) + 1;

  localparam logic signed [SXW-1:0] PCX_S = SXW'(PCX);
  localparam logic signed [SYW-1:0] PCY_S = SYW'(PCY);
  localparam logic signed [SXW-1:0] P0X_S = SXW'(P0X);
  localparam logic signed [SYW-1:0] P0Y_S = SYW'(P0Y);
  localparam logic signed [SXW-1:0] P1X_S = SXW'(P1X);
  localparam logic signed [SYW-1:0] P1Y_S = SYW'(P1Y);
  localparam logic signed [SXW-1:0] P2X_S = SXW'(P2X);
  localparam logic signed [SYW-1:0] P2Y_S = SYW'(P2Y);
  localparam logic signed [MW-1:0]  RAD   = MW'(RADIUS);
  localparam logic signed [MW:0]    RAD_S = (MW+1)'(RADIUS);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [XW-1:0]      pl_x_p0;
  logic [YW-1:0]      pl_y_p0;
  logic [XW-1:0]      en_x_p0 [N_ENEMY];
  logic [YW-1:0]      en_y_p0 [N_ENEMY];
  logic [N_ENEMY-1:0] en_valid_p0;
  logic [IDXW-1:0]    idx;
  logic [N_ENEMY-1:0] work_mask;
  logic               vld_p1;

  logic signed [SXW-1:0] cx, ex;
  logic signed [SYW-1:0] cy, ey;
  logic signed [SXW-1:0] dx0, dx1, dx2;
  logic signed [SYW-1:0] dy0, dy1, dy2;
  logic                  slot_hit;

  // Square test everywhere, clipped to a diamond when the probe sits above the centre.
  function automatic logic probe_hit(input logic signed [SXW-1:0] dx,
                                     input logic signed [SYW-1:0] dy);
    logic signed [MW-1:0] ax, ay;
    logic signed [MW:0]   sum;
    ax  = MW'(dx);
    ay  = MW'(dy);
    ax  = ax[MW-1] ? -ax : ax;
    ay  = ay[MW-1] ? -ay : ay;
    sum = {ax[MW-1], ax} + {ay[MW-1], ay};
    return (ax < RAD) && (ay < RAD) && (!dy[SYW-1] || (sum < RAD_S));
  endfunction

  function automatic logic [IDXW-1:0] lowest_set(input logic [N_ENEMY-1:0] m);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (m[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  always_comb begin
    cx  = $signed({2'b00, pl_x_p0}) + PCX_S;
    cy  = $signed({2'b00, pl_y_p0}) + PCY_S;
    ex  = $signed({2'b00, en_x_p0[idx]});
    ey  = $signed({2'b00, en_y_p0[idx]});
    dx0 = ex + P0X_S - cx;
    dy0 = ey + P0Y_S - cy;
    dx1 = ex + P1X_S - cx;
    dy1 = ey + P1Y_S - cy;
    dx2 = ex + P2X_S - cx;
    dy2 = ey + P2Y_S - cy;
    slot_hit = en_valid_p0[idx] &&
               (probe_hit(dx0, dy0) || probe_hit(dx1, dy1) || probe_hit(dx2, dy2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (idx == IDXW'(N_ENEMY - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = vld_p1;
  end

  // p0: snapshot on accepted start; scan stage fills work_mask; p1: publish results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl_x_p0       <= '0;
      pl_y_p0       <= '0;
      en_valid_p0   <= '0;
      for (int i = 0; i < N_ENEMY; i++) begin
        en_x_p0[i] <= '0;
        en_y_p0[i] <= '0;
      end
      idx           <= '0;
      work_mask     <= '0;
      hit_mask      <= '0;
      hit_any       <= 1'b0;
      first_hit_idx <= '0;
      vld_p1        <= 1'b0;
      crash         <= 1'b0;
    end else begin
      vld_p1 <= (state == S_DONE);
      if (state == S_IDLE && start) begin
        pl_x_p0     <= pl_x;
        pl_y_p0     <= pl_y;
        en_valid_p0 <= en_valid;
        for (int i = 0; i < N_ENEMY; i++) begin
          en_x_p0[i] <= en_x[i*XW +: XW];
          en_y_p0[i] <= en_y[i*YW +: YW];
        end
        idx       <= '0;
        work_mask <= '0;
      end
      if (state == S_SCAN) begin
        work_mask[idx] <= slot_hit;
        idx            <= idx + IDXW'(1);
      end
      if (state == S_DONE) begin
        hit_mask      <= work_mask;
        hit_any       <= |work_mask;
        first_hit_idx <= lowest_set(work_mask);
      end
      if (state == S_DONE && (|work_mask)) crash <= 1'b1;
      else if (crash_ack)                  crash <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crash_scanner.sv
// Directed and randomized bench for crash_scanner against an integer reference of the hit rules.
module tb_crash_scanner;

  localparam int N    = 8;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int IDXW = 3;
  localparam int OX [3] = '{32, 2, 62};
  localparam int OY [3] = '{77, 30, 30};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [XW-1:0]   pl_x;
  logic [YW-1:0]   pl_y;
  logic [N*XW-1:0] en_x;
  logic [N*YW-1:0] en_y;
  logic [N-1:0]    en_valid;
  logic            crash_ack;
  logic            busy, done, hit_any, crash;
  logic [N-1:0]    hit_mask;
  logic [IDXW-1:0] first_hit_idx;

  int n_cmp  = 0;
  int n_fail = 0;
  bit crash_m = 1'b0;

  crash_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pl_x(pl_x), .pl_y(pl_y),
    .en_x(en_x), .en_y(en_y), .en_valid(en_valid), .crash_ack(crash_ack),
    .busy(busy), .done(done), .hit_mask(hit_mask), .hit_any(hit_any),
    .first_hit_idx(first_hit_idx), .crash(crash)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hit(input int plx, input int ply, input int ex, input int ey);
    int cx, cy, dx, dy, ax, ay;
    cx = plx + 40;
    cy = ply + 41;
    for (int k = 0; k < 3; k++) begin
      dx = ex + OX[k] - cx;
      dy = ey + OY[k] - cy;
      ax = (dx < 0) ? -dx : dx;
      ay = (dy < 0) ? -dy : dy;
      if (ax < 38 && ay < 38 && (dy >= 0 || ax + ay < 38)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] ref_mask();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      m[i] = en_valid[i] && ref_hit(int'(pl_x), int'(pl_y),
                                    int'(en_x[i*XW +: XW]), int'(en_y[i*YW +: YW]));
    return m;
  endfunction

  function automatic int ref_first(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic set_slot(input int i, input int x, input int y);
    en_x[i*XW +: XW] = XW'(x);
    en_y[i*YW +: YW] = YW'(y);
  endtask

  task automatic set_all(input int x, input int y);
    for (int i = 0; i < N; i++) set_slot(i, x, y);
    en_valid = '1;
  endtask

  task automatic scramble();
    pl_x     = XW'($urandom);
    pl_y     = YW'($urandom);
    en_valid = N'($urandom);
    for (int i = 0; i < N; i++) set_slot(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
  endtask

  // Caller is at #1 after an edge; start is sampled at the next edge.
  task automatic run_scan(input string tag, input bit ack_on_done, input bit poke_start);
    logic [N-1:0] m;
    int k;
    bit seen;
    m = ref_mask();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    scramble();
    k = 0;
    seen = 1'b0;
    while (!seen && k < N + 6) begin
      if (k == N && ack_on_done) crash_ack = 1'b1;
      if (k == 3 && poke_start) start = 1'b1;
      @(posedge clk); #1;
      k++;
      crash_ack = 1'b0;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (|m)             crash_m = 1'b1;
    else if (ack_on_done) crash_m = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'(N + 1));
    check({tag, "_mask"}, 32'(hit_mask), 32'(m));
    check({tag, "_any"}, 32'(hit_any), 32'(|m));
    check({tag, "_first"}, 32'(first_hit_idx), 32'(ref_first(m)));
    check({tag, "_crash"}, 32'(crash), 32'(crash_m));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int px, py, ex, ey;
    rst_n = 1'b0;
    start = 1'b0;
    crash_ack = 1'b0;
    pl_x = '0;
    pl_y = '0;
    en_x = '0;
    en_y = '0;
    en_valid = '0;
    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mask", 32'(hit_mask), 32'd0);
    check("rst_first", 32'(first_hit_idx), 32'd0);
    check("rst_crash", 32'(crash), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Nose exactly on the player centre
    set_all(800, 400);
    pl_x = 10'd100; pl_y = 9'd100;
    set_slot(3, 108, 64);
    run_scan("t1", 1'b0, 1'b0);
    check("t1_mask_k", 32'(hit_mask), 32'h08);
    check("t1_first_k", 32'(first_hit_idx), 32'd3);
    check("t1_crash_k", 32'(crash), 32'd1);

    // Diamond top vs lower square and the strict radius edge
    pl_x = 10'd100; pl_y = 9'd100;
    en_valid = '1;
    set_slot(0, 128, 44);  set_slot(1, 128, 84);
    set_slot(2, 145, 64);  set_slot(3, 71, 64);
    set_slot(4, 146, 64);  set_slot(5, 70, 64);
    set_slot(6, 108, 101); set_slot(7, 108, 102);
    run_scan("t2", 1'b0, 1'b0);
    check("t2_mask_k", 32'(hit_mask), 32'h4E);
    check("t2_first_k", 32'(first_hit_idx), 32'd1);

    // Dead slot overlapping the player never hits
    set_all(800, 400);
    pl_x = 10'd100; pl_y = 9'd100;
    set_slot(2, 108, 64);
    set_slot(5, 108, 64);
    en_valid[2] = 1'b0;
    run_scan("t3", 1'b0, 1'b0);
    check("t3_mask_k", 32'(hit_mask), 32'h20);
    check("t3_first_k", 32'(first_hit_idx), 32'd5);

    // Screen-edge coordinates must not wrap
    set_all(600, 300);
    pl_x = '0; pl_y = '0;
    set_slot(0, 1000, 0);
    set_slot(1, 8, 0);
    set_slot(2, 8, 500);
    run_scan("t4", 1'b0, 1'b0);
    check("t4_mask_k", 32'(hit_mask), 32'h02);

    // No hits: crash stays sticky
    set_all(800, 400);
    pl_x = 10'd100; pl_y = 9'd100;
    run_scan("t4b", 1'b0, 1'b0);
    check("t4b_crash_k", 32'(crash), 32'd1);

    // Start during a scan is dropped
    set_all(800, 400);
    pl_x = 10'd100; pl_y = 9'd100;
    set_slot(3, 108, 64);
    run_scan("t5", 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("t5_no_done", 32'(done), 32'd0);
      check("t5_idle", 32'(busy), 32'd0);
    end

    // Reset mid-scan aborts with no done
    set_all(800, 400);
    pl_x = 10'd100; pl_y = 9'd100;
    set_slot(3, 108, 64);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    crash_m = 1'b0;
    check("t5r_busy", 32'(busy), 32'd0);
    check("t5r_done", 32'(done), 32'd0);
    check("t5r_mask", 32'(hit_mask), 32'd0);
    check("t5r_any", 32'(hit_any), 32'd0);
    check("t5r_first", 32'(first_hit_idx), 32'd0);
    check("t5r_crash", 32'(crash), 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("t5r_done_cnt", 32'(done_cnt), 32'd0);

    // Ack on the hitting done edge loses to the set
    set_all(800, 400);
    pl_x = 10'd100; pl_y = 9'd100;
    set_slot(3, 108, 64);
    run_scan("t6", 1'b1, 1'b0);
    check("t6_crash_k", 32'(crash), 32'd1);
    crash_ack = 1'b1;
    @(posedge clk); #1;
    crash_ack = 1'b0;
    crash_m = 1'b0;
    check("t6_ack_clear", 32'(crash), 32'd0);
    @(posedge clk); #1;

    // Randomized back-to-back scans clustered around the player
    for (int r = 0; r < 40; r++) begin
      px = int'($urandom_range(0, 1023));
      py = int'($urandom_range(0, 511));
      pl_x = XW'(px);
      pl_y = YW'(py);
      for (int i = 0; i < N; i++) begin
        ex = px + int'($urandom_range(0, 140)) - 100;
        ey = py + int'($urandom_range(0, 140)) - 110;
        if (ex < 0) ex = 0;
        if (ex > 1023) ex = 1023;
        if (ey < 0) ey = 0;
        if (ey > 511) ey = 511;
        set_slot(i, ex, ey);
      end
      en_valid = N'($urandom);
      run_scan("rnd", bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
